// File: rtl/sprite_pixel_emitter.sv
// Buffers packed sprite words in a small FIFO and expands each horizontal run into clipped VGA pixel writes.
// Build macro TRANSPARENT_KEY_EN additionally suppresses pixels whose colour equals KEY_COLOUR.
module sprite_pixel_emitter #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         SCREEN_W   = 160,
  parameter int         SCREEN_H   = 120,
  parameter logic [2:0] KEY_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] word,
  input  logic [7:0]  x_coord,
  input  logic [6:0]  y_coord,
  input  logic        out_stall,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        busy
);
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [8:0] W_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] H_LIMIT = 8'(SCREEN_H);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;

  logic [15:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [0:0]  r_state;
  logic [4:0]  r_dx;
  logic [4:0]  r_dy;
  logic [2:0]  r_colour;
  logic [1:0]  r_run;
  logic [1:0]  r_i;
  logic        r_opaque;
  logic [7:0]  r_x0;
  logic [6:0]  r_y0;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour_out;
  logic        r_we;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_emit;
  logic        w_last;
  logic        w_key;
  logic        w_visible;
  logic [8:0]  w_xs;
  logic [7:0]  w_ys;
  logic [15:0] w_head;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  // A stall freezes the whole emitter, including the IDLE pop, so queued words stay in the FIFO.
  assign w_emit = (r_state == EMIT) && !out_stall;
  assign w_last = (r_i == r_run);
  assign w_pop  = !w_empty && !out_stall && ((r_state == IDLE) || w_last);

  assign w_xs = {1'b0, r_x0} + {4'b0, r_dx} + {7'b0, r_i};
  assign w_ys = {1'b0, r_y0} + {3'b0, r_dy};

`ifdef TRANSPARENT_KEY_EN
  assign w_key = (r_colour == KEY_COLOUR);
`else
  // Colour keying is compiled out; the comparison is masked so the parameter stays referenced.
  assign w_key = 1'b0 & (r_colour == KEY_COLOUR);
`endif

  assign w_visible = r_opaque && (w_xs < W_LIMIT) && (w_ys < H_LIMIT) && !w_key;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_state      <= IDLE;
      r_dx         <= '0;
      r_dy         <= '0;
      r_colour     <= '0;
      r_run        <= '0;
      r_i          <= '0;
      r_opaque     <= 1'b0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour_out <= '0;
      r_we         <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dx     <= w_head[15:11];
        r_dy     <= w_head[10:6];
        r_colour <= w_head[5:3];
        r_run    <= w_head[2:1];
        r_opaque <= w_head[0];
        r_x0     <= x_coord;
        r_y0     <= y_coord;
        r_i      <= '0;
        r_state  <= EMIT;
      end else if (w_emit) begin
        if (w_last) begin
          r_state <= IDLE;
        end else begin
          r_i <= r_i + 2'd1;
        end
      end
      // Clipped and transparent pixels still update x/y/colour; only the strobe is suppressed.
      if (w_emit) begin
        r_x          <= w_xs[7:0];
        r_y          <= w_ys[6:0];
        r_colour_out <= r_colour;
        r_we         <= w_visible;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign x       = r_x;
  assign y       = r_y;
  assign colour  = r_colour_out;
  assign writeEn = r_we;
  assign busy    = !w_empty || (r_state == EMIT) || r_we;

endmodule

// File: tb/tb_sprite_pixel_emitter.sv
// Directed bench for sprite_pixel_emitter: per-scenario tasks with hand-computed pixel streams.
module tb_sprite_pixel_emitter;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] word;
  logic [7:0]  x_coord;
  logic [6:0]  y_coord;
  logic        out_stall;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Expected writeEn / x per edge for the mid-run stall scenario (index 0 unused).
  int stall_we [9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
  int stall_x  [9] = '{0, 0, 50, 51, 51, 51, 52, 53, 0};

  always #5 clock = ~clock;

  sprite_pixel_emitter dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .word      (word),
    .x_coord   (x_coord),
    .y_coord   (y_coord),
    .out_stall (out_stall),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .writeEn   (writeEn),
    .busy      (busy)
  );

  always @(posedge clock) begin
    #1;
    if (writeEn === 1'b1) $display("write x=%0d y=%0d colour=%0d", x, y, colour);
  end

  function automatic logic [15:0] mk(input int dx, input int dy, input int col, input int run1, input int op);
    return {5'(dx), 5'(dy), 3'(col), 2'(run1), 1'(op)};
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [15:0] w);
    in_valid = 1'b1;
    word     = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_stall = 1'b0; word = '0; x_coord = '0; y_coord = '0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (writeEn !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", writeEn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if ({x, y, colour} !== 18'd0) begin failures++; $display("FAIL reset_xyc got=%0d/%0d/%0d exp=0/0/0", x, y, colour); end
  endtask

  task automatic test_basic;
    logic exp_we;
    x_coord = 8'd10; y_coord = 7'd20;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
    push_one(mk(3, 4, 5, 2, 1));
    for (int k = 0; k < 6; k++) begin
      exp_we = (k >= 2 && k <= 4);
      checks++; if (writeEn !== exp_we) begin failures++; $display("FAIL basic_we k=%0d got=%b exp=%b", k, writeEn, exp_we); end
      if (exp_we) begin
        checks++;
        if ({x, y, colour} !== {8'(11 + k), 7'd24, 3'd5}) begin
          failures++; $display("FAIL basic_xyc k=%0d got=%0d/%0d/%0d exp=%0d/24/5", k, x, y, colour, 11 + k);
        end
      end
      if (k == 5) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
      end else begin
        step();
      end
    end
  endtask

  task automatic test_back_to_back;
    out_stall = 1'b1; x_coord = 8'd30; y_coord = 7'd40;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; word = mk(k, 0, k + 1, 0, 1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, in_ready); end
      step();
    end
    word = mk(4, 0, 5, 0, 1);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_hold got=%b exp=0", in_ready); end
    checks++; if (writeEn !== 1'b0) begin failures++; $display("FAIL b2b_stall_we got=%b exp=0", writeEn); end
    out_stall = 1'b0;
    step();
    checks++; if (writeEn !== 1'b0) begin failures++; $display("FAIL b2b_first_pop_we got=%b exp=0", writeEn); end
    for (int j = 0; j < 6; j++) begin
      if (j == 1) word = mk(5, 0, 6, 0, 1);
      if (j >= 2) in_valid = 1'b0;
      if (j < 2) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_refill j=%0d got=%b exp=1", j, in_ready); end
      end
      step();
      checks++;
      if ({writeEn, x, y, colour} !== {1'b1, 8'(30 + j), 7'd40, 3'(j + 1)}) begin
        failures++; $display("FAIL b2b_px j=%0d got=%b %0d/%0d/%0d exp=1 %0d/40/%0d", j, writeEn, x, y, colour, 30 + j, j + 1);
      end
    end
    step();
    checks++; if ({writeEn, busy} !== 2'b00) begin failures++; $display("FAIL b2b_done got=%b%b exp=00", writeEn, busy); end
  endtask

  task automatic test_clip;
    logic exp_we;
    x_coord = 8'd158; y_coord = 7'd119;
    push_one(mk(0, 0, 3, 3, 1));
    for (int k = 0; k < 6; k++) begin
      exp_we = (k == 2 || k == 3);
      checks++; if (writeEn !== exp_we) begin failures++; $display("FAIL clip_we k=%0d got=%b exp=%b", k, writeEn, exp_we); end
      if (k >= 2) begin
        checks++;
        if ({x, y} !== {8'(156 + k), 7'd119}) begin
          failures++; $display("FAIL clip_xy k=%0d got=%0d/%0d exp=%0d/119", k, x, y, 156 + k);
        end
      end
      if (k >= 4) begin
        checks++;
        if (busy !== (k == 4)) begin failures++; $display("FAIL clip_busy k=%0d got=%b exp=%b", k, busy, k == 4); end
      end
      if (k < 5) step();
    end
  endtask

  task automatic test_stall_mid;
    x_coord = 8'd50; y_coord = 7'd60;
    push_one(mk(0, 0, 7, 3, 1));
    for (int k = 1; k < 9; k++) begin
      out_stall = (k == 4 || k == 5);
      step();
      checks++;
      if (writeEn !== 1'(stall_we[k])) begin
        failures++; $display("FAIL stall_we edge=%0d got=%b exp=%0d", k, writeEn, stall_we[k]);
      end
      if (k >= 2 && k <= 7) begin
        checks++;
        if ({x, y, colour} !== {8'(stall_x[k]), 7'd60, 3'd7}) begin
          failures++; $display("FAIL stall_xyc edge=%0d got=%0d/%0d/%0d exp=%0d/60/7", k, x, y, colour, stall_x[k]);
        end
      end
    end
    out_stall = 1'b0;
  endtask

  task automatic test_reset_mid;
    x_coord = 8'd70; y_coord = 7'd80;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; word = (k == 0) ? mk(0, 0, 6, 3, 1) : mk(k, 0, 6, 0, 1);
      step();
    end
    in_valid = 1'b0;
    checks++; if (writeEn !== 1'b1) begin failures++; $display("FAIL rstmid_running got=%b exp=1", writeEn); end
    reset = 1'b1;
    step();
    checks++; if ({writeEn, busy, in_ready} !== 3'b001) begin
      failures++; $display("FAIL rstmid_flush got=we%b busy%b rdy%b exp=we0 busy0 rdy1", writeEn, busy, in_ready);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if ({writeEn, busy} !== 2'b00) begin failures++; $display("FAIL rstmid_quiet k=%0d got=%b%b exp=00", k, writeEn, busy); end
    end
    x_coord = 8'd5; y_coord = 7'd6;
    push_one(mk(1, 1, 2, 0, 1));
    step(); step();
    checks++; if ({writeEn, x, y, colour} !== {1'b1, 8'd6, 7'd7, 3'd2}) begin
      failures++; $display("FAIL rstmid_after got=%b %0d/%0d/%0d exp=1 6/7/2", writeEn, x, y, colour);
    end
    step();
    checks++; if (writeEn !== 1'b0) begin failures++; $display("FAIL rstmid_after_end got=%b exp=0", writeEn); end
  endtask

  task automatic test_transparent;
    x_coord = 8'd0; y_coord = 7'd0;
    push_one(mk(0, 0, 4, 1, 0));
    for (int k = 0; k < 4; k++) begin
      checks++; if (writeEn !== 1'b0) begin failures++; $display("FAIL transp_we k=%0d got=%b exp=0", k, writeEn); end
      if (k >= 2) begin
        checks++; if (busy !== (k == 2)) begin failures++; $display("FAIL transp_busy k=%0d got=%b exp=%b", k, busy, k == 2); end
      end
      if (k < 3) step();
    end
  endtask

  task automatic test_key;
    logic exp_we;
`ifdef TRANSPARENT_KEY_EN
    exp_we = 1'b0;
`else
    exp_we = 1'b1;
`endif
    x_coord = 8'd1; y_coord = 7'd2;
    push_one(mk(0, 0, 0, 0, 1));
    step(); step();
    checks++; if (writeEn !== exp_we) begin failures++; $display("FAIL key_we got=%b exp=%b", writeEn, exp_we); end
    checks++; if ({x, y, colour} !== {8'd1, 7'd2, 3'd0}) begin
      failures++; $display("FAIL key_xyc got=%0d/%0d/%0d exp=1/2/0", x, y, colour);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clip();
    test_stall_mid();
    test_reset_mid();
    test_transparent();
    test_key();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_emitter.md
Name: sprite_pixel_emitter

Overview:
Downstream stage of the sprite ROM readers (Kevin, BlackSnowman, ...).
- Accepts packed 16-bit sprite words through a valid/ready handshake and buffers them in a small FIFO.
- Expands each word's horizontal run into individual pixel writes at screen coordinates: sprite origin plus word offset.
- Clips writes to the 160x120 frame and drives x/y/colour/writeEn straight into the VGA adapter.

Parameters:
FIFO_DEPTH, 4, input word buffer entries (power of two, >=2)
SCREEN_W, 160, writes with x >= SCREEN_W suppressed
SCREEN_H, 120, writes with y >= SCREEN_H suppressed
KEY_COLOUR, 3'b000, transparent colour (used only with optional feature)

Ports:
clock  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
in_valid  input  1  word present on word
in_ready  output  1  FIFO can accept; transfer when in_valid & in_ready at posedge
word  input  16  [15:11] dx, [10:6] dy, [5:3] colour, [2:1] run-1, [0] opaque
x_coord  input  8  sprite origin x
y_coord  input  7  sprite origin y
out_stall  input  1  VGA side cannot take a write this cycle
x  output  8  pixel x
y  output  7  pixel y
colour  output  3  pixel colour
writeEn  output  1  pixel write strobe, one cycle per pixel
busy  output  1  FIFO non-empty or run in progress

Behaviour:
Reset:
- FIFO is emptied and the state is IDLE.
- Outputs: x=0, y=0, colour=0, writeEn=0, busy=0. in_ready=1 in the cycle after reset deasserts.
- A reset during a run aborts it immediately. No further writeEn occurs for flushed words.

FIFO:
- in_ready = !full. There is no pass-through when full.
- Push and pop in the same cycle are legal at any non-full occupancy.
- Read and write pointers are log2(FIFO_DEPTH)+1 bits with natural wrap-around.

Origin capture:
- x_coord and y_coord are sampled into working registers at the pop edge.
- Origin changes mid-run do not affect the current word.

State machine:
- IDLE: if FIFO non-empty, pop to working registers (dx, dy, colour, count=run, opaque, origin) and go to EMIT.
- EMIT: each non-stalled cycle emits pixel i (i = 0..run), then increments i.
- When i == run and the pixel is emitted, pop the next word in the same edge if available and stay in EMIT. Otherwise go to IDLE.
- Back-to-back words produce no bubble cycles.

Arithmetic:
- xs = x_coord + dx + i, computed 9 bits wide. ys = y_coord + dy, computed 8 bits wide.
- writeEn = opaque & (xs < SCREEN_W) & (ys < SCREEN_H) & !stall.
- x = xs[7:0], y = ys[6:0].

Transparent and clipped pixels:
- opaque=0: the word still occupies run+1 cycles with writeEn=0, so the cycle count is independent of content.
- Clipped pixels also consume their cycle with writeEn=0.

Output timing:
- x, y, colour and writeEn are registered.
- First writeEn is high 2 cycles after the acceptance edge when the block was idle with an empty FIFO.

Stall:
- out_stall high: the emitter does not advance and the registered writeEn is 0 for that cycle.
- x, y and colour hold their values. The pending pixel is emitted once out_stall is low.
- FIFO pushes continue during stall.

Timing and flags:
- A run of k pixels gives k consecutive writeEn cycles absent stall and clipping.
- busy = !empty | (state==EMIT) | writeEn.

Optional Feature:
TRANSPARENT_KEY_EN:
- Defined: a pixel is also suppressed (writeEn=0, cycle still consumed) when the word's colour == KEY_COLOUR, regardless of the opaque bit.
- Undefined: only the opaque bit governs transparency and KEY_COLOUR is unused.

Test Plan:
- Reset, origin (10,20), push word dx=3, dy=4, colour=5, run-1=2, opaque=1 -> writeEn high 3 cycles, starting 2 cycles after acceptance, at (13,24), (14,24), (15,24), colour 5; busy low afterwards.
- Push 6 words with run-1=0 while out_stall=1 -> in_ready drops after 4 accepted. Release stall -> 6 writes in 6 consecutive cycles, no bubbles, in push order.
- Origin (158,119), word dx=0, dy=0, run-1=3 -> writes at x=158 and 159 only; x=160 and 161 give writeEn=0. Total 4 cycles consumed.
- Toggle out_stall high for 2 cycles mid-run -> writeEn low for those 2 cycles, x/y held, no pixel lost or duplicated.
- Assert reset while 3 words are queued and mid-run -> next cycle writeEn=0, busy=0, in_ready=1; later words emit normally.
- With TRANSPARENT_KEY_EN defined, word colour=0 and opaque=1 -> no writeEn. Without the macro -> pixel written with colour 0.
